// File: rtl/Modules_pkg.sv
// Shared types for the multi-port integer register file: data word, ABI register
// names and the clear/ready state encoding.
package Modules_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_ADDR_W = 5;

    typedef logic [PKG_DATA_W-1:0] data_bus_t;

    typedef enum logic [PKG_ADDR_W-1:0] {
        REG_ZERO, REG_RA, REG_SP, REG_GP, REG_TP, REG_T0, REG_T1, REG_T2,
        REG_S0,   REG_S1, REG_A0, REG_A1, REG_A2, REG_A3, REG_A4, REG_A5,
        REG_A6,   REG_A7, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_S8,   REG_S9, REG_S10, REG_S11, REG_T3, REG_T4, REG_T5, REG_T6
    } i_register_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_write_arbiter.sv
// Resolves the write ports into one enable and one data word per register; the
// same per-register view doubles as the bypass match vector for the read ports.
module rf_write_arbiter
    import Modules_pkg::*;
#(
    parameter int DATA_W   = PKG_DATA_W,
    parameter int ADDR_W   = PKG_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [NUM_WR-1:0]             i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]      i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]      i_wr_data,
    output logic [(2**ADDR_W)-1:0]        o_reg_we,
    output logic [(2**ADDR_W)*DATA_W-1:0] o_reg_data
);

    logic [ADDR_W-1:0] w_addr;

    // Ports are visited in ascending order so the highest index overwrites lower ones.
    always_comb begin
        o_reg_we   = '0;
        o_reg_data = '0;
        w_addr     = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_addr = i_wr_addr[p*ADDR_W +: ADDR_W];
            if (i_wr_en[p] && !((ZERO_REG != 0) && (w_addr == '0))) begin
                o_reg_we[w_addr]                    = 1'b1;
                o_reg_data[w_addr*DATA_W +: DATA_W] = i_wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/i_reg_file_mp.sv
// Multi-port integer register file with post-reset clear sweep, optional
// write-to-read bypass and a per-register pending-write scoreboard.
module i_reg_file_mp
    import Modules_pkg::*;
#(
    parameter int DATA_W   = PKG_DATA_W,
    parameter int ADDR_W   = PKG_ADDR_W,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     ready_o,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i
);

    localparam int DEPTH = 2**ADDR_W;

    rf_state_e             r_state;
    rf_state_e             w_state_nxt;
    logic [ADDR_W-1:0]     r_sweep_cnt;
    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;

    logic                  w_ready;
    logic [NUM_WR-1:0]     w_wr_en;
    logic [DEPTH-1:0]      w_reg_we;
    logic [DEPTH*DATA_W-1:0] w_reg_data;
    logic                  w_rsv_valid;
    logic [ADDR_W-1:0]     w_rd_addr;

    assign w_ready     = (r_state == READY);
    assign ready_o     = w_ready;
    assign w_wr_en     = wr_en_i & {NUM_WR{w_ready}};
    assign w_rsv_valid = rsv_en_i && w_ready && !((ZERO_REG != 0) && (rsv_addr_i == '0));

    rf_write_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_arb (
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (wr_addr_i),
        .i_wr_data  (wr_data_i),
        .o_reg_we   (w_reg_we),
        .o_reg_data (w_reg_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= CLEAR;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == CLEAR) && (r_sweep_cnt == ADDR_W'(DEPTH-1))) begin
            w_state_nxt = READY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)                 r_sweep_cnt <= '0;
        else if (r_state == CLEAR) r_sweep_cnt <= r_sweep_cnt + 1'b1;
    end

    // No reset on the array itself: the sweep zeroes one entry per cycle instead.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < DEPTH; r++) begin
            if (r_state == CLEAR) begin
                if (r_sweep_cnt == ADDR_W'(r)) r_mem[r] <= '0;
            end else if (w_reg_we[r]) begin
                r_mem[r] <= w_reg_data[r*DATA_W +: DATA_W];
            end
        end
    end

    // A same-cycle reserve is applied after the write clear so the new producer wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else if (w_ready) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (w_reg_we[r]) r_busy[r] <= 1'b0;
            end
            if (w_rsv_valid) r_busy[rsv_addr_i] <= 1'b1;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        w_rd_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_addr = rd_addr_i[i*ADDR_W +: ADDR_W];
            if (w_ready && !((ZERO_REG != 0) && (w_rd_addr == '0))) begin
                if ((BYPASS != 0) && w_reg_we[w_rd_addr]) begin
                    rd_data_o[i*DATA_W +: DATA_W] = w_reg_data[w_rd_addr*DATA_W +: DATA_W];
                    rd_busy_o[i] = w_rsv_valid && (rsv_addr_i == w_rd_addr);
                end else begin
                    rd_data_o[i*DATA_W +: DATA_W] = r_mem[w_rd_addr];
                    rd_busy_o[i] = r_busy[w_rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_i_reg_file_mp.sv
// Bench for i_reg_file_mp: a bypass and a non-bypass instance share stimulus and
// are checked every cycle against an array-based model plus literal expectations.
module tb_i_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_a [3];
    logic [1:0]  wr_en;
    logic [4:0]  wr_a [2];
    logic [31:0] wr_d [2];
    logic        rsv_en;
    logic [4:0]  rsv_a;

    logic [14:0] rd_addr_f;
    logic [9:0]  wr_addr_f;
    logic [63:0] wr_data_f;
    assign rd_addr_f = {rd_a[2], rd_a[1], rd_a[0]};
    assign wr_addr_f = {wr_a[1], wr_a[0]};
    assign wr_data_f = {wr_d[1], wr_d[0]};

    logic        ready_b, ready_n;
    logic [95:0] rd_data_b, rd_data_n;
    logic [2:0]  busy_b, busy_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i_reg_file_mp #(.BYPASS(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .ready_o(ready_b),
        .rd_addr_i(rd_addr_f), .rd_data_o(rd_data_b), .rd_busy_o(busy_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr_f), .wr_data_i(wr_data_f),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_a)
    );

    i_reg_file_mp #(.BYPASS(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .ready_o(ready_n),
        .rd_addr_i(rd_addr_f), .rd_data_o(rd_data_n), .rd_busy_o(busy_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr_f), .wr_data_i(wr_data_f),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_a)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [32];
    logic        m_busy [32];
    int          m_left  = 0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left  <= 32;
            m_valid <= 1'b1;
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  <= 32'h0;
                m_busy[r] <= 1'b0;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_a[p] != 5'd0) begin
                    m_mem[wr_a[p]]  <= wr_d[p];
                    m_busy[wr_a[p]] <= 1'b0;
                end
            end
            if (rsv_en && rsv_a != 5'd0) m_busy[rsv_a] <= 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [4:0]  c_a;
    logic        c_hit, eb_b, en_b;
    logic [31:0] c_bd, eb_d, en_d;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready_bypass", ready_b, m_left == 0);
            chk("ready_nobypass", ready_n, m_left == 0);
            for (int i = 0; i < 3; i++) begin
                c_a   = rd_a[i];
                c_hit = 1'b0;
                c_bd  = 32'h0;
                for (int p = 0; p < 2; p++) begin
                    if (wr_en[p] && wr_a[p] == c_a && c_a != 5'd0) begin
                        c_hit = 1'b1;
                        c_bd  = wr_d[p];
                    end
                end
                if (m_left != 0 || c_a == 5'd0) begin
                    eb_d = 32'h0; eb_b = 1'b0; en_d = 32'h0; en_b = 1'b0;
                end else begin
                    en_d = m_mem[c_a];
                    en_b = m_busy[c_a];
                    eb_d = c_hit ? c_bd : m_mem[c_a];
                    eb_b = c_hit ? (rsv_en && rsv_a == c_a) : m_busy[c_a];
                end
                chk("rd_data_bypass", rd_data_b[i*32 +: 32], eb_d);
                chk("rd_busy_bypass", busy_b[i], eb_b);
                chk("rd_data_nobypass", rd_data_n[i*32 +: 32], en_d);
                chk("rd_busy_nobypass", busy_n[i], en_b);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        rsv_en = 1'b0;
    endtask

    task automatic count_ready(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (ready_b) break;
            n++;
        end
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    int cnt;

    initial begin
        rst = 1'b1;
        idle();
        rsv_a = 5'd0;
        for (int i = 0; i < 3; i++) rd_a[i] = 5'd0;
        for (int p = 0; p < 2; p++) begin
            wr_a[p] = 5'd0;
            wr_d[p] = 32'h0;
        end

        // reset sweep, with a write attempted during the sweep
        repeat (3) tick();
        wr_en   = 2'b01;
        wr_a[0] = 5'd5;
        wr_d[0] = 32'h0000_DEAD;
        rd_a[0] = 5'd5;
        rst     = 1'b0;
        cnt     = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (ready_b) break;
            cnt++;
            if (cnt == 4) begin
                @(posedge clk);
                #1;
                idle();
            end
        end
        chk("sweep_len", cnt, 32);
        tick();
        for (int a = 0; a < 32; a++) begin
            rd_a[0] = 5'(a);
            rd_a[1] = 5'(31 - a);
            @(negedge clk);
            chk("sweep_zero", rd_data_b[31:0], 32'h0);
            tick();
        end

        // reset asserted mid-sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_ready(cnt);
        chk("midsweep_len", cnt, 32);
        tick();

        // write conflict and x0
        wr_en = 2'b11; wr_a[0] = 5'd7; wr_a[1] = 5'd7;
        wr_d[0] = 32'h1111; wr_d[1] = 32'h2222; rd_a[0] = 5'd7;
        @(negedge clk);
        chk("conflict_bypass_now", rd_data_b[31:0], 32'h2222);
        chk("conflict_nobypass_now", rd_data_n[31:0], 32'h0);
        tick(); idle();
        @(negedge clk);
        chk("conflict_bypass_after", rd_data_b[31:0], 32'h2222);
        chk("conflict_nobypass_after", rd_data_n[31:0], 32'h2222);
        tick();
        wr_en = 2'b01; wr_a[0] = 5'd0; wr_d[0] = 32'hFFFF; rd_a[0] = 5'd0;
        @(negedge clk);
        chk("x0_write_now", rd_data_b[31:0], 32'h0);
        tick(); idle();
        @(negedge clk);
        chk("x0_write_after", rd_data_b[31:0], 32'h0);
        chk("x0_write_after_nb", rd_data_n[31:0], 32'h0);

        // bypass vs stored value
        tick();
        wr_en = 2'b01; wr_a[0] = 5'd3; wr_d[0] = 32'hABCD; rd_a[1] = 5'd3;
        @(negedge clk);
        chk("bypass_same_cycle", rd_data_b[63:32], 32'hABCD);
        chk("nobypass_same_cycle", rd_data_n[63:32], 32'h0);
        tick(); idle();
        @(negedge clk);
        chk("nobypass_next_cycle", rd_data_n[63:32], 32'hABCD);

        // scoreboard
        tick();
        rsv_en = 1'b1; rsv_a = 5'd9; rd_a[2] = 5'd9;
        @(negedge clk);
        chk("rsv_same_cycle", busy_b[2], 1'b0);
        tick(); idle();
        @(negedge clk);
        chk("rsv_set_b", busy_b[2], 1'b1);
        chk("rsv_set_n", busy_n[2], 1'b1);
        tick();
        wr_en = 2'b01; wr_a[0] = 5'd9; wr_d[0] = 32'h55;
        @(negedge clk);
        chk("wr_clear_bypass_now", busy_b[2], 1'b0);
        chk("wr_clear_nobypass_now", busy_n[2], 1'b1);
        tick(); idle();
        @(negedge clk);
        chk("wr_clear_b", busy_b[2], 1'b0);
        chk("wr_clear_n", busy_n[2], 1'b0);
        tick();
        wr_en = 2'b10; wr_a[1] = 5'd9; wr_d[1] = 32'h66; rsv_en = 1'b1; rsv_a = 5'd9;
        @(negedge clk);
        chk("rsv_wr_bypass_now", busy_b[2], 1'b1);
        tick(); idle();
        @(negedge clk);
        chk("rsv_wins_b", busy_b[2], 1'b1);
        chk("rsv_wins_n", busy_n[2], 1'b1);
        chk("rsv_wr_data", rd_data_n[95:64], 32'h66);
        tick();
        rsv_en = 1'b1; rsv_a = 5'd0; rd_a[2] = 5'd0;
        tick(); idle();
        @(negedge clk);
        chk("rsv_x0_b", busy_b[2], 1'b0);
        chk("rsv_x0_n", busy_n[2], 1'b0);

        // all reads on one address; every port writing a distinct address
        tick();
        rd_a[0] = 5'd3; rd_a[1] = 5'd3; rd_a[2] = 5'd3;
        tick();
        wr_en = 2'b11; wr_a[0] = 5'd10; wr_a[1] = 5'd11;
        wr_d[0] = 32'hA0A0; wr_d[1] = 32'hB1B1;
        rd_a[0] = 5'd10; rd_a[1] = 5'd11; rd_a[2] = 5'd3;
        tick(); idle();
        @(negedge clk);
        chk("distinct_p0", rd_data_n[31:0], 32'hA0A0);
        chk("distinct_p1", rd_data_n[63:32], 32'hB1B1);

        // random regression
        for (int k = 0; k < 10000; k++) begin
            tick();
            rst   = ($urandom_range(0, 999) == 0);
            wr_en = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                wr_a[p] = rand_addr();
                wr_d[p] = $urandom;
            end
            rsv_en = ($urandom_range(0, 3) == 0);
            rsv_a  = rand_addr();
            for (int i = 0; i < 3; i++) rd_a[i] = rand_addr();
        end
        tick();
        rst = 1'b0;
        idle();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
